// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: FIFO-buffered issue stage feeding a combinational bf16 fpu, with a registered result stage
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [3:0]                 in_op_i,
  input  logic [15:0]                in_a_i,
  input  logic [15:0]                in_b_i,
  output logic [3:0]                 fpu_op_o,
  output logic [15:0]                fpu_in1_o,
  output logic [15:0]                fpu_in2_o,
  input  logic [15:0]                fpu_out_i,
  input  logic                       fpu_ovf_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [15:0]                res_data_o,
  output logic                       res_ovf_o,
  output logic                       res_illegal_o,
  input  logic                       clr_sticky_i,
  output logic                       sticky_ovf_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [CNT_W-1:0]           done_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [35:0]   head;
  logic          push, pop, head_legal, not_empty;
  assign head       = mem[rd_ptr];
  assign head_legal = $onehot(head[35:32]);
  assign not_empty  = level_o != '0;
  // Readiness depends only on occupancy, so a full queue never accepts a same-cycle push-through
  assign in_ready_o = !rst && level_o < (AW+1)'(DEPTH);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = not_empty && (!res_valid_o || res_ready_i);
  assign fpu_op_o   = (not_empty && head_legal) ? head[35:32] : 4'b0;
  assign fpu_in1_o  = (not_empty && head_legal) ? head[31:16] : 16'h0;
  assign fpu_in2_o  = (not_empty && head_legal) ? head[15:0]  : 16'h0;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_op_i, in_a_i, in_b_i};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_o       <= '0;
      res_valid_o   <= 1'b0;
      res_data_o    <= 16'h0;
      res_ovf_o     <= 1'b0;
      res_illegal_o <= 1'b0;
      sticky_ovf_o  <= 1'b0;
      done_cnt_o    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level_o <= level_o + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        res_valid_o   <= 1'b1;
        res_data_o    <= head_legal ? fpu_out_i : 16'h7FC0;
        res_ovf_o     <= head_legal && fpu_ovf_i;
        res_illegal_o <= !head_legal;
      end else if (res_ready_i) begin
        res_valid_o <= 1'b0;
      end
      sticky_ovf_o <= (pop && head_legal && fpu_ovf_i) || (sticky_ovf_o && !clr_sticky_i);
      done_cnt_o   <= done_cnt_o + CNT_W'(res_valid_o && res_ready_i);
    end
  end
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: directed and random-stream checks of the issue queue against a bf16 fpu stand-in
module tb_fpu_issue_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a, in_b;
  logic [3:0]  fpu_op;
  logic [15:0] fpu_in1, fpu_in2, fpu_out;
  logic        fpu_ovf;
  logic        res_valid, res_ready, res_ovf, res_illegal;
  logic [15:0] res_data;
  logic        clr_sticky, sticky_ovf;
  logic [2:0]  level;
  logic [15:0] done_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Truncating bf16 model standing in for the fpu; returns {overflow, result}
  function automatic logic [16:0] fpu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic sa, sb, s;
    int ea, eb, ma, mb, m, e, t;
    logic [15:0] bb;
    if (op != 4'b0001 && op != 4'b0010 && op != 4'b0100 && op != 4'b1000) return 17'h0;
    bb = (op == 4'b0010) ? {~b[15], b[14:0]} : b;
    sa = a[15];
    sb = bb[15];
    ea = int'(a[14:7]);
    eb = int'(bb[14:7]);
    ma = (ea == 0) ? 0 : 128 + int'(a[6:0]);
    mb = (eb == 0) ? 0 : 128 + int'(bb[6:0]);
    if (op[0] || op[1]) begin
      if (ma == 0) return {1'b0, bb};
      if (mb == 0) return {1'b0, a};
      if (ea < eb || (ea == eb && ma < mb)) begin
        t = ea; ea = eb; eb = t;
        t = ma; ma = mb; mb = t;
        s = sa; sa = sb; sb = s;
      end
      s = sa;
      mb = (ea - eb > 15) ? 0 : mb >> (ea - eb);
      m = (sa == sb) ? ma + mb : ma - mb;
      if (m == 0) return 17'h0;
      e = ea;
    end else if (op[2]) begin
      s = sa ^ sb;
      if (ma == 0 || mb == 0) return {1'b0, s, 15'h0};
      m = (ma * mb) >> 7;
      e = ea + eb - 127;
    end else begin
      s = sa ^ sb;
      if (mb == 0) return {1'b1, s, 8'hFF, 7'h0};
      if (ma == 0) return {1'b0, s, 15'h0};
      m = (ma << 8) / mb;
      e = ea - eb + 126;
    end
    while (m >= 256) begin m = m >> 1; e++; end
    while (m < 128) begin m = m << 1; e--; end
    if (e >= 255) return {1'b1, s, 8'hFF, 7'h0};
    if (e <= 0) return {1'b0, s, 15'h0};
    return {1'b0, s, e[7:0], m[6:0]};
  endfunction

  assign {fpu_ovf, fpu_out} = fpu_ref(fpu_op, fpu_in1, fpu_in2);

  fpu_issue_queue #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b),
    .fpu_op_o(fpu_op), .fpu_in1_o(fpu_in1), .fpu_in2_o(fpu_in2), .fpu_out_i(fpu_out), .fpu_ovf_i(fpu_ovf),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_ovf_o(res_ovf),
    .res_illegal_o(res_illegal), .clr_sticky_i(clr_sticky), .sticky_ovf_o(sticky_ovf),
    .level_o(level), .done_cnt_o(done_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", level); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
    n_cmp++; if (done_cnt !== 16'd0) begin n_err++; $display("FAIL rst_done: got %0d expected 0", done_cnt); end
    n_cmp++; if (sticky_ovf !== 1'b0) begin n_err++; $display("FAIL rst_sticky: got %b expected 0", sticky_ovf); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add;
    res_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'b0001; in_a = 16'h3F80; in_b = 16'h4000;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL add_level: got %0d expected 1", level); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid: got %b expected 0", res_valid); end
    n_cmp++; if (fpu_op !== 4'b0001) begin n_err++; $display("FAIL add_fpu_op: got %b expected 0001", fpu_op); end
    n_cmp++; if (fpu_in2 !== 16'h4000) begin n_err++; $display("FAIL add_fpu_in2: got %h expected 4000", fpu_in2); end
    tick();
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b expected 1", res_valid); end
    n_cmp++; if (res_data !== 16'h4040) begin n_err++; $display("FAIL add_data: got %h expected 4040", res_data); end
    n_cmp++; if (res_ovf !== 1'b0) begin n_err++; $display("FAIL add_ovf: got %b expected 0", res_ovf); end
    tick();
    n_cmp++; if (done_cnt !== 16'd1) begin n_err++; $display("FAIL add_done: got %0d expected 1", done_cnt); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL add_drained: got %b expected 0", res_valid); end
  endtask

  task automatic test_back_pressure;
    logic [15:0] bp_b [6];
    logic [15:0] bp_exp [6];
    int got, sent;
    bp_b   = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0};
    bp_exp = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0};
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 4'b0001; in_a = 16'h3F80; in_b = bp_b[i];
      tick();
    end
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL bp_full_level: got %0d expected 4", level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    n_cmp++; if (res_data !== 16'h4000) begin n_err++; $display("FAIL bp_held_data: got %h expected 4000", res_data); end
    in_b = bp_b[5];
    tick();
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL bp_blocked_level: got %0d expected 4", level); end
    n_cmp++; if (res_data !== 16'h4000 || res_valid !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %h/%b expected 4000/1", res_data, res_valid); end
    res_ready = 1'b1;
    got = 0;
    sent = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      #1;
      if (res_valid && res_ready) begin
        n_cmp++; if (res_data !== bp_exp[got]) begin n_err++; $display("FAIL bp_order[%0d]: got %h expected %h", got, res_data, bp_exp[got]); end
        got++;
      end
      if (in_valid && in_ready) sent = 1;
      tick();
      if (sent != 0) in_valid = 1'b0;
    end
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL bp_count: got %0d expected 6", got); end
    n_cmp++; if (sent != 1) begin n_err++; $display("FAIL bp_sixth_accepted: got %0d expected 1", sent); end
    n_cmp++; if (done_cnt !== 16'd7) begin n_err++; $display("FAIL bp_done: got %0d expected 7", done_cnt); end
  endtask

  task automatic test_overflow;
    clr_sticky = 1'b0;
    res_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'b0100; in_a = 16'h7F00; in_b = 16'h7F00;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (res_data !== 16'h7F80) begin n_err++; $display("FAIL ovf_data: got %h expected 7f80", res_data); end
    n_cmp++; if (res_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", res_ovf); end
    n_cmp++; if (sticky_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky_set: got %b expected 1", sticky_ovf); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    tick();
    n_cmp++; if (res_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_second_flag: got %b expected 1", res_ovf); end
    n_cmp++; if (sticky_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b expected 1", sticky_ovf); end
    tick();
    clr_sticky = 1'b0;
    n_cmp++; if (sticky_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_cleared: got %b expected 0", sticky_ovf); end
  endtask

  task automatic test_illegal;
    res_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'b0011; in_a = 16'h3F80; in_b = 16'h3F80;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (fpu_op !== 4'b0000) begin n_err++; $display("FAIL ill_fpu_op: got %b expected 0000", fpu_op); end
    n_cmp++; if (fpu_in1 !== 16'h0 || fpu_in2 !== 16'h0) begin n_err++; $display("FAIL ill_fpu_in: got %h/%h expected 0/0", fpu_in1, fpu_in2); end
    tick();
    n_cmp++; if (res_data !== 16'h7FC0) begin n_err++; $display("FAIL ill_data: got %h expected 7fc0", res_data); end
    n_cmp++; if (res_illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag: got %b expected 1", res_illegal); end
    n_cmp++; if (res_ovf !== 1'b0 || sticky_ovf !== 1'b0) begin n_err++; $display("FAIL ill_ovf: got %b/%b expected 0/0", res_ovf, sticky_ovf); end
    in_valid = 1'b1; in_op = 4'b0000;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (res_illegal !== 1'b1 || res_data !== 16'h7FC0) begin n_err++; $display("FAIL ill_zero_op: got %b/%h expected 1/7fc0", res_illegal, res_data); end
    in_valid = 1'b1; in_op = 4'b0100; in_b = 16'h4000;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (res_illegal !== 1'b0 || res_data !== 16'h4000) begin n_err++; $display("FAIL ill_then_legal: got %b/%h expected 0/4000", res_illegal, res_data); end
    tick();
  endtask

  task automatic test_stream;
    logic [16:0] sb [$];
    logic [16:0] exp_v;
    int sent, got;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    sent = 0;
    got = 0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      if (sent < 1000) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_op = 4'(1 << $urandom_range(0, 3));
        in_a = 16'($urandom);
        in_b = 16'($urandom);
      end else in_valid = 1'b0;
      res_ready = $urandom_range(0, 2) != 0;
      #1;
      if (in_valid && in_ready) begin
        sb.push_back(fpu_ref(in_op, in_a, in_b));
        sent++;
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL stream_spurious: got %h expected no result", res_data);
        end else begin
          exp_v = sb.pop_front();
          n_cmp++; if ({res_ovf, res_data} !== exp_v || res_illegal !== 1'b0) begin n_err++; $display("FAIL stream[%0d]: got %b/%h expected %b/%h", got, res_ovf, res_data, exp_v[16], exp_v[15:0]); end
        end
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL stream_count: got %0d expected 1000", got); end
    n_cmp++; if (done_cnt !== 16'd1000) begin n_err++; $display("FAIL stream_done: got %0d expected 1000", done_cnt); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL stream_level: got %0d expected 0", level); end
  endtask

  task automatic test_reset_mid;
    int stale;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = 4'b0001; in_a = 16'h3F80; in_b = 16'h3F80;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (level !== 3'd3 || res_valid !== 1'b1) begin n_err++; $display("FAIL mid_setup: got %0d/%b expected 3/1", level, res_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b expected 0", in_ready); end
    tick();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL mid_level: got %0d expected 0", level); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b expected 0", res_valid); end
    n_cmp++; if (done_cnt !== 16'd0 || sticky_ovf !== 1'b0) begin n_err++; $display("FAIL mid_counters: got %0d/%b expected 0/0", done_cnt, sticky_ovf); end
    rst = 1'b0;
    res_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (res_valid) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL mid_stale: got %0d results expected 0", stale); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 4'b0; in_a = 16'h0; in_b = 16'h0;
    res_ready = 1'b0; clr_sticky = 1'b0;
    test_reset();
    test_add();
    test_back_pressure();
    test_overflow();
    test_illegal();
    test_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
